// File: rtl/xgmii_pkg.sv
// ---------------------------------------------------------------------------
// xgmii_pkg
// Shared definitions for the XGMII receive-side frame scheduler.
//   - XGMII idle / start / terminate encodings
//   - ingress and egress FSM state types
//   - lane_byte(): pulls one 8-bit lane out of a 64-bit XGMII data word
// ---------------------------------------------------------------------------
package xgmii_pkg;

    localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;
    localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  XGMII_START  = 8'hFB;
    localparam logic [7:0]  XGMII_TERM   = 8'hFD;

    typedef enum logic [1:0] {
        I_IDLE,
        I_FRAME,
        I_DROP
    } ingress_state_t;

    typedef enum logic {
        E_IDLE,
        E_SEND
    } egress_state_t;

    // Lane 0 occupies bits 7:0, lane 7 occupies bits 63:56.
    function automatic logic [7:0] lane_byte(input logic [63:0] data, input int unsigned lane);
        return data[lane*8 +: 8];
    endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// ---------------------------------------------------------------------------
// frame_buf_ram
// Simple dual-port RAM used as the store-and-forward frame buffer.
// One write port and one synchronous read port on the same clock; no reset.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable (rdata updates on the clock after re is high)
//   raddr  : read address
//   rdata  : registered read data
// ---------------------------------------------------------------------------
module frame_buf_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 72
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/xgmii_rx_frame_sched.sv
// ---------------------------------------------------------------------------
// xgmii_rx_frame_sched
// Store-and-forward scheduler between the GMII->XGMII async FIFO and the
// XGMII receive bus. Whole frames are collected in a local buffer and only
// then replayed back-to-back onto the bus, so a slow 1G writer can never
// cause a mid-frame underrun at 10G. Idle is driven at all other times and a
// minimum idle gap is inserted between frames.
//   xgmii_clk  : sole clock
//   sys_rst    : synchronous active-high reset
//   fifo_dout  : FIFO read data {ctl[7:0], data[63:0]}, valid cycle after fifo_rd_en
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : FIFO read strobe
//   xgmii_rxc  : XGMII control lanes (lane 0 = bit 0)
//   xgmii_rxd  : XGMII data lanes (lane 0 = bits 7:0)
//   frame_cnt  : frames forwarded (wraps)
//   drop_cnt   : frames dropped on buffer overflow (wraps)
// ---------------------------------------------------------------------------
module xgmii_rx_frame_sched
    import xgmii_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int IFG_WORDS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             xgmii_clk,
    input  logic             sys_rst,
    input  logic [71:0]      fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [7:0]       xgmii_rxc,
    output logic [63:0]      xgmii_rxd,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int         DEPTH      = 1 << ADDR_W;
    localparam logic [3:0] IFG_RELOAD = 4'(IFG_WORDS);

    // Ingress side
    logic           in_valid;
    logic [7:0]     in_ctl;
    logic [63:0]    in_data;
    logic           in_sof;
    logic           in_eof;
    ingress_state_t i_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_commit;
    logic           buf_full;
    logic           wr_accept;
    logic           ram_we;
    logic           commit;

    // Egress side
    egress_state_t  e_state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] stored_cnt;
    logic [3:0]     ifg_cnt;
    logic           ram_re;
    logic           eg_last;
    logic           rd_valid_q;
    logic [71:0]    ram_q;

    // One flag per buffer word marking the frame's final word. It is read
    // combinationally at the read address so egress knows, at the moment it
    // issues a read, that this read is the last one of the frame; this is
    // what lets it stop without reading past EOF.
    logic           eof_mark [0:DEPTH-1];

    // The FIFO is drained whenever it has data; overflow is resolved by
    // dropping frames, never by back-pressuring the FIFO.
    assign fifo_rd_en = !fifo_empty && !sys_rst;

    assign in_ctl  = fifo_dout[71:64];
    assign in_data = fifo_dout[63:0];

    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            in_valid <= 1'b0;
        end else begin
            in_valid <= fifo_rd_en;
        end
    end

    always_comb begin
        in_sof = in_ctl[0] && (lane_byte(in_data, 0) == XGMII_START);
        in_eof = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (in_ctl[i] && (lane_byte(in_data, i) == XGMII_TERM)) begin
                in_eof = 1'b1;
            end
        end
    end

    // A word must be stored when it opens a frame or continues one; a SOF
    // arriving inside a frame is just data.
    assign buf_full  = (wr_ptr + ADDR_W'(1)) == rd_ptr;
    assign wr_accept = in_valid && (((i_state == I_IDLE) && in_sof) || (i_state == I_FRAME));
    assign ram_we    = wr_accept && !buf_full;
    assign commit    = ram_we && in_eof;

    // Ingress FSM: writes speculatively at wr_ptr and only advances
    // wr_commit at EOF, so an overflowing frame is discarded by rewinding
    // wr_ptr to the last committed boundary.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            i_state   <= I_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            drop_cnt  <= '0;
        end else if (in_valid) begin
            case (i_state)
                I_IDLE, I_FRAME: begin
                    if (wr_accept) begin
                        if (buf_full) begin
                            wr_ptr   <= wr_commit;
                            drop_cnt <= drop_cnt + CNT_W'(1);
                            i_state  <= in_eof ? I_IDLE : I_DROP;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                            if (in_eof) begin
                                wr_commit <= wr_ptr + ADDR_W'(1);
                                i_state   <= I_IDLE;
                            end else begin
                                i_state <= I_FRAME;
                            end
                        end
                    end
                end
                I_DROP: begin
                    if (in_eof) begin
                        i_state <= I_IDLE;
                    end
                end
                default: begin
                    i_state <= I_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge xgmii_clk) begin
        if (ram_we) begin
            eof_mark[wr_ptr] <= in_eof;
        end
    end

    frame_buf_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (72)
    ) u_buf (
        .clk   (xgmii_clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (fifo_dout),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // Egress reads every cycle while sending; from idle it starts only when
    // a complete frame is held and the idle gap has elapsed.
    assign ram_re  = (e_state == E_SEND) ||
                     ((e_state == E_IDLE) && (stored_cnt != '0) && (ifg_cnt == 4'd0));
    assign eg_last = ram_re && eof_mark[rd_ptr];

    // Egress FSM. The IFG counter is reloaded on the EOF read, so the number
    // of idle words seen on the bus between frames equals IFG_WORDS.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            e_state   <= E_IDLE;
            rd_ptr    <= '0;
            ifg_cnt   <= IFG_RELOAD;
            frame_cnt <= '0;
        end else begin
            case (e_state)
                E_IDLE: begin
                    if (ram_re) begin
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                        if (eg_last) begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                            ifg_cnt   <= IFG_RELOAD;
                        end else begin
                            e_state <= E_SEND;
                        end
                    end else if (ifg_cnt != 4'd0) begin
                        ifg_cnt <= ifg_cnt - 4'd1;
                    end
                end
                E_SEND: begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                    if (eg_last) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        ifg_cnt   <= IFG_RELOAD;
                        e_state   <= E_IDLE;
                    end
                end
                default: begin
                    e_state <= E_IDLE;
                end
            endcase
        end
    end

    // A commit and an egress EOF in the same cycle cancel out.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            stored_cnt <= '0;
        end else begin
            case ({commit, eg_last})
                2'b10:   stored_cnt <= stored_cnt + ADDR_W'(1);
                2'b01:   stored_cnt <= stored_cnt - ADDR_W'(1);
                default: stored_cnt <= stored_cnt;
            endcase
        end
    end

    // Output register: RAM data lands one cycle after the read, and is
    // registered once more onto the bus, giving a two-cycle read-to-bus delay.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            rd_valid_q <= 1'b0;
            xgmii_rxc  <= XGMII_IDLE_C;
            xgmii_rxd  <= XGMII_IDLE_D;
        end else begin
            rd_valid_q <= ram_re;
            if (rd_valid_q) begin
                xgmii_rxc <= ram_q[71:64];
                xgmii_rxd <= ram_q[63:0];
            end else begin
                xgmii_rxc <= XGMII_IDLE_C;
                xgmii_rxd <= XGMII_IDLE_D;
            end
        end
    end

endmodule
